// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, data width, requester id and response-slot state.
package alu_pkg;
    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    typedef logic req_id_t;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} rsp_state_e;
endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU with unsigned compare flags.
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              eq_o,
    output logic              gt_o,
    output logic              lt_o
);
    // Shift distance is the whole B operand, so anything >= 32 clears the result.
    logic shift_ovf;
    assign shift_ovf = (b_i[DATA_W-1:5] != '0);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_SLL:  result_o = shift_ovf ? '0 : (a_i << b_i[4:0]);
            ALU_SRL:  result_o = shift_ovf ? '0 : (a_i >> b_i[4:0]);
            ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            default:  result_o = '0;
        endcase
    end

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU: round-robin grant, one-entry response register,
// saturating per-requester grant counters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_eq,
    output logic              rsp_gt,
    output logic              rsp_lt,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);
    rsp_state_e        state_q;
    req_id_t           rr_q, rsp_id_q, gnt_id;
    logic [DATA_W-1:0] rsp_result_q, mux_a, mux_b, alu_res;
    logic [2:0]        mux_op;
    logic              rsp_eq_q, rsp_gt_q, rsp_lt_q, alu_eq, alu_gt, alu_lt;
    logic              slot_free, xfer;
    logic [CNT_W-1:0]  cnt0_q, cnt1_q, cnt0_d, cnt1_d;

    assign rsp_valid = (state_q == ST_FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    // Contention resolves through rr; a lone requester always wins.
    assign gnt_id = (req0_valid && req1_valid) ? rr_q : req_id_t'(req1_valid);

    assign req0_ready = !rst && slot_free && req0_valid && (gnt_id == 1'b0);
    assign req1_ready = !rst && slot_free && req1_valid && (gnt_id == 1'b1);
    assign xfer       = req0_ready || req1_ready;

    assign mux_a  = gnt_id ? req1_a  : req0_a;
    assign mux_b  = gnt_id ? req1_b  : req0_b;
    assign mux_op = gnt_id ? req1_op : req0_op;

    alu_share_arbiter_alu u_alu (
        .op_i     (mux_op),
        .a_i      (mux_a),
        .b_i      (mux_b),
        .result_o (alu_res),
        .eq_o     (alu_eq),
        .gt_o     (alu_gt),
        .lt_o     (alu_lt)
    );

    assign cnt0_d = (req0_ready && cnt0_q != '1) ? cnt0_q + 1'b1 : cnt0_q;
    assign cnt1_d = (req1_ready && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            rr_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_eq_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_lt_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            if (xfer) begin
                state_q      <= ST_FULL;
                rr_q         <= ~gnt_id;
                rsp_id_q     <= gnt_id;
                rsp_result_q <= alu_res;
                rsp_eq_q     <= alu_eq;
                rsp_gt_q     <= alu_gt;
                rsp_lt_q     <= alu_lt;
            end else if (state_q == ST_FULL && rsp_ready) begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_eq     = rsp_eq_q;
    assign rsp_gt     = rsp_gt_q;
    assign rsp_lt     = rsp_lt_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a CNT_W=2 copy shares the stimulus for saturation.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt;
    logic [31:0] rsp_result;
    logic [15:0] grant_cnt0, grant_cnt1;
    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_eq, s_gt, s_lt;
    logic [31:0] s_result;
    logic [1:0]  s_cnt0, s_cnt1;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_share_arbiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_result(s_result),
        .rsp_eq(s_eq), .rsp_gt(s_gt), .rsp_lt(s_lt),
        .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] res, input logic id,
                           input logic eq, input logic gt, input logic lt);
        chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".id"}, {31'd0, rsp_id}, {31'd0, id});
        chk({tag, ".result"}, rsp_result, res);
        chk({tag, ".flags"}, {29'd0, rsp_eq, rsp_gt, rsp_lt}, {29'd0, eq, gt, lt});
    endtask

    task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        set0(1'b1, 3'b000, 32'd0, 32'd0);
        set1(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        chk("rst.ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.result", rsp_result, 32'd0);
        chk("rst.cnt", {grant_cnt0, grant_cnt1}, 32'd0);
        rst = 1'b0;

        // ADD 5+7 from requester 0
        set0(1'b1, 3'b000, 32'd5, 32'd7);
        #1;
        chk("add.ready", {30'd0, req0_ready, req1_ready}, 32'b10);
        tick();
        chk_rsp("add", 32'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("add.cnt0", {16'd0, grant_cnt0}, 32'd1);

        // Round-robin alternation from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        set0(1'b1, 3'b000, 32'd1, 32'd2);
        set1(1'b1, 3'b010, 32'hF0, 32'hFF);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr.ready", {30'd0, req0_ready, req1_ready}, (i % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            if (i % 2 == 0) chk_rsp("rr.g0", 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
            else            chk_rsp("rr.g1", 32'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("rr.cnt0", {16'd0, grant_cnt0}, 32'd2);
        chk("rr.cnt1", {16'd0, grant_cnt1}, 32'd2);

        // SUB then backpressure for 3 cycles, inputs wiggling underneath
        set0(1'b0, 3'b000, 32'd0, 32'd0);
        set1(1'b1, 3'b001, 32'd3, 32'd10);
        tick();
        chk_rsp("sub", 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0, 1'b1);
        rsp_ready = 1'b0;
        set0(1'b1, 3'b011, 32'h0F0, 32'h00F);
        set1(1'b1, 3'b000, 32'd100, 32'd100);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold.ready", {30'd0, req0_ready, req1_ready}, 32'b00);
            tick();
            chk_rsp("hold", 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        set1(1'b0, 3'b000, 32'd0, 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("drainxfer.ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        chk_rsp("drainxfer", 32'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drainxfer.cnt", {grant_cnt0, grant_cnt1}, {16'd3, 16'd3});

        // Edge opcodes
        set0(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1); tick();
        chk_rsp("sltu.big", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        set0(1'b1, 3'b101, 32'd1, 32'd40); tick();
        chk_rsp("sll40", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        set0(1'b1, 3'b101, 32'd1, 32'd31); tick();
        chk_rsp("sll31", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        set0(1'b1, 3'b110, 32'h8000_0000, 32'd4); tick();
        chk_rsp("srl4", 32'h0800_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        set0(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1_0000); tick();
        chk_rsp("srlbig", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        set0(1'b1, 3'b111, 32'd1, 32'd2); tick();
        chk_rsp("sltu.lt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        set0(1'b1, 3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF); tick();
        chk_rsp("and", 32'h00F0_1234, 1'b0, 1'b0, 1'b1, 1'b0);
        set0(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        chk_rsp("add.eq", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);

        // Drain with no new transfer
        set0(1'b0, 3'b000, 32'd0, 32'd0); tick();
        chk("drain.valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while full and requester 0 waiting
        set0(1'b1, 3'b000, 32'd2, 32'd2); tick();
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        chk("midrst.valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst.result", rsp_result, 32'd0);
        chk("midrst.cnt", {grant_cnt0, grant_cnt1}, 32'd0);
        rst = 1'b0; rsp_ready = 1'b1;
        set1(1'b1, 3'b000, 32'd0, 32'd0);
        #1;
        chk("midrst.rr0", {30'd0, req0_ready, req1_ready}, 32'b10);

        // Saturation: 5 requester-0 transfers on both instances
        set1(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (5) tick();
        chk("sat.wide", {16'd0, grant_cnt0}, 32'd5);
        chk("sat.narrow", {30'd0, s_cnt0}, 32'd3);
        chk("sat.narrow1", {30'd0, s_cnt1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
